// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and frame geometry constants.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_LO = 3'd1;
  localparam logic [2:0] ST_HDR_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    HDR_LO = ST_HDR_LO,
    HDR_HI = ST_HDR_HI,
    DATA   = ST_DATA,
    CHK    = ST_CHK,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_word_pack.sv
// Packs a little-endian byte stream into 32-bit words. The first three bytes
// of a word are shifted into a holding register; the fourth byte is inserted
// combinationally so the completed word is presented in the same cycle it is
// accepted.
module byte_word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q;
  logic [23:0] low_q;

  // Byte position counter and shift register for the lower three bytes; a new
  // frame start discards any partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (byte_en_i) begin
      cnt_q <= cnt_q + 2'd1;
      low_q <= {byte_i, low_q[23:8]};
    end
  end

  assign word_valid_o = byte_en_i && (cnt_q == LastByte);
  assign word_o       = {byte_i, low_q};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream (2-byte word count,
// then the words LSB first), writes the words to the instruction memory and
// holds the core in reset while loading.
// Optional checksum byte after the data is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_SIZE  = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core,
  input  logic        Load_Start,
  input  logic        Byte_Valid,
  input  logic [7:0]  Byte_Data,
  output logic        Byte_Ready,
  output logic        Mem_Wr_En,
  output logic [31:0] Mem_Wr_Addr,
  output logic [31:0] Mem_Wr_Data,
  output logic        Core_Hold,
  output logic        Load_Done,
  output logic        Load_Error
);

  localparam logic [15:0] MemSizeW = 16'(MEM_SIZE);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] wordIdx_q, wordIdx_d;
  logic        wrEn_q, wrEn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        byteReady;
  logic        xfer;
  logic        startAccept;
  logic [15:0] nHdr;
  logic        packWordValid;
  logic [31:0] packWord;

  assign byteReady   = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                       (state_q == DATA)   || (state_q == CHK);
  assign xfer        = Byte_Valid && byteReady;
  assign startAccept = Load_Start &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign nHdr        = {Byte_Data, count_q[7:0]};

  byte_word_pack uPack (
    .clk_i        (Clk_Core),
    .rst_i        (Rst_Core),
    .clear_i      (startAccept),
    .byte_en_i    (xfer && (state_q == DATA)),
    .byte_i       (Byte_Data),
    .word_valid_o (packWordValid),
    .word_o       (packWord)
  );

  // Next-state and output-register logic for the frame FSM.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wordIdx_d = wordIdx_q;
    wrEn_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    error_d   = error_q;
    hold_d    = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (startAccept) begin
          state_d   = HDR_LO;
          count_d   = '0;
          wordIdx_d = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          hold_d    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      HDR_LO: begin
        if (xfer) begin
          count_d = {8'h00, Byte_Data};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          count_d = nHdr;
          if (nHdr > MemSizeW) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (nHdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ Byte_Data;
`endif
          if (packWordValid) begin
            wrEn_d    = 1'b1;
            addr_d    = BASE_ADDR + {14'd0, wordIdx_q, 2'b00};
            data_d    = packWord;
            wordIdx_d = wordIdx_q + 16'd1;
            if (wordIdx_q == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end
          end
        end
      end
      CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (Byte_Data == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops every output including the hold.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wordIdx_q <= '0;
      wrEn_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wordIdx_q <= wordIdx_d;
      wrEn_q    <= wrEn_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hold_q    <= hold_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of the data bytes of the current frame.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) chk_q <= '0;
    else          chk_q <= chk_d;
  end
`endif

  assign Byte_Ready  = byteReady;
  assign Mem_Wr_En   = wrEn_q;
  assign Mem_Wr_Addr = addr_q;
  assign Mem_Wr_Data = data_q;
  assign Core_Hold   = hold_q;
  assign Load_Done   = done_q;
  assign Load_Error  = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected memory writes are queued as
// frames are driven and matched against the write port as strobes appear.
// Works with and without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int          MemSize  = 128;
   localparam logic [31:0] BaseAddr = 32'h0;

   logic        clk = 1'b0;
   logic        Rst_Core;
   logic        Load_Start;
   logic        Byte_Valid;
   logic [7:0]  Byte_Data;
   logic        Byte_Ready;
   logic        Mem_Wr_En;
   logic [31:0] Mem_Wr_Addr;
   logic [31:0] Mem_Wr_Data;
   logic        Core_Hold;
   logic        Load_Done;
   logic        Load_Error;

   int checks = 0;
   int errors = 0;
   int writeCount = 0;
   logic [63:0] expQ[$];
   logic [31:0] frameWords[$];

   imem_loader #(.MEM_SIZE(MemSize), .BASE_ADDR(BaseAddr)) dut (
      .Clk_Core   (clk),
      .Rst_Core   (Rst_Core),
      .Load_Start (Load_Start),
      .Byte_Valid (Byte_Valid),
      .Byte_Data  (Byte_Data),
      .Byte_Ready (Byte_Ready),
      .Mem_Wr_En  (Mem_Wr_En),
      .Mem_Wr_Addr(Mem_Wr_Addr),
      .Mem_Wr_Data(Mem_Wr_Data),
      .Core_Hold  (Core_Hold),
      .Load_Done  (Load_Done),
      .Load_Error (Load_Error)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case anything wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Match every write strobe against the scoreboard.
   always @(negedge clk) begin
      if (Mem_Wr_En === 1'b1) begin
         logic [63:0] e;
         writeCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", Mem_Wr_Addr, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("wrAddr", Mem_Wr_Addr, e[63:32]);
            checkOutput("wrData", Mem_Wr_Data, e[31:0]);
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseStart();
      @(negedge clk);
      Load_Start = 1'b1;
      @(negedge clk);
      Load_Start = 1'b0;
   endtask

   // Offer one byte and hold it until the loader takes it.
   task automatic applyStimulus(input logic [7:0] b, input bit gaps, input bit pulse);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      Byte_Valid = 1'b1;
      Byte_Data  = b;
      Load_Start = pulse;
      n = 0;
      while (Byte_Ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) checkOutput("byteReadyTimeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      Byte_Valid = 1'b0;
      Load_Start = 1'b0;
   endtask

   // Drive a whole frame built from frameWords, queueing the expected writes.
   task automatic sendFrame(input bit badChk, input bit gaps, input int pulseAt);
      logic [15:0] n;
      logic [7:0]  x;
      logic [31:0] w;
      n = 16'(frameWords.size());
      x = 8'h00;
      pulseStart();
      checkOutput("holdAfterStart", {31'd0, Core_Hold}, 32'd1);
      applyStimulus(n[7:0], gaps, 1'b0);
      applyStimulus(n[15:8], gaps, 1'b0);
      for (int i = 0; i < frameWords.size(); i++) begin
         w = frameWords[i];
         expQ.push_back({BaseAddr + 32'(4 * i), w});
         for (int k = 0; k < 4; k++) begin
            x = x ^ w[8*k +: 8];
            applyStimulus(w[8*k +: 8], gaps, (i * 4 + k) == pulseAt);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      applyStimulus(badChk ? (x ^ 8'h01) : x, gaps, 1'b0);
`else
      if (badChk) $display("[TB] checksum byte not used in this build");
`endif
      waitCycles(3);
   endtask

   task automatic checkStatus(input string tag, input bit done, input bit err, input bit hold);
      checkOutput({tag, "_done"}, {31'd0, Load_Done}, {31'd0, done});
      checkOutput({tag, "_error"}, {31'd0, Load_Error}, {31'd0, err});
      checkOutput({tag, "_hold"}, {31'd0, Core_Hold}, {31'd0, hold});
      checkOutput({tag, "_ready"}, {31'd0, Byte_Ready}, 32'd0);
      checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, {31'd0, Byte_Ready}, 32'd0);
      checkOutput({tag, "_wrEn"}, {31'd0, Mem_Wr_En}, 32'd0);
      checkOutput({tag, "_addr"}, Mem_Wr_Addr, 32'd0);
      checkOutput({tag, "_data"}, Mem_Wr_Data, 32'd0);
      checkOutput({tag, "_hold"}, {31'd0, Core_Hold}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, Load_Done}, 32'd0);
      checkOutput({tag, "_error"}, {31'd0, Load_Error}, 32'd0);
   endtask

   initial begin
      int wc;
      Rst_Core   = 1'b1;
      Load_Start = 1'b1;
      Byte_Valid = 1'b1;
      Byte_Data  = 8'hAA;

      // Reset with valid bytes offered: everything stays quiet.
      waitCycles(3);
      checkAllZero("reset");
      checkOutput("resetWrites", 32'(writeCount), 32'd0);
      Rst_Core   = 1'b0;
      Load_Start = 1'b0;
      Byte_Valid = 1'b0;
      waitCycles(2);
      checkOutput("idleReady", {31'd0, Byte_Ready}, 32'd0);

      // Two-word program.
      frameWords = '{32'h0000_0013, 32'h0010_0093};
      sendFrame(1'b0, 1'b0, -1);
      checkStatus("twoWords", 1'b1, 1'b0, 1'b0);
      checkOutput("holdWrEn", {31'd0, Mem_Wr_En}, 32'd0);
      checkOutput("holdAddr", Mem_Wr_Addr, 32'h4);
      checkOutput("holdData", Mem_Wr_Data, 32'h0010_0093);

      // Oversized image is rejected with no writes.
      wc = writeCount;
      pulseStart();
      checkOutput("errStartDone", {31'd0, Load_Done}, 32'd0);
      applyStimulus(8'h81, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      waitCycles(3);
      checkStatus("tooBig", 1'b0, 1'b1, 1'b1);
      checkOutput("tooBigWrites", 32'(writeCount), 32'(wc));

      // Empty image.
      frameWords = {};
      sendFrame(1'b0, 1'b0, -1);
      checkStatus("empty", 1'b1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendFrame(1'b1, 1'b0, -1);
      checkStatus("emptyBadChk", 1'b0, 1'b1, 1'b1);
`endif
      checkOutput("emptyWrites", 32'(writeCount), 32'(wc));

      // Gappy stream with a stray start pulse mid-data.
      frameWords = '{32'h0000_0013, 32'h0010_0093};
      sendFrame(1'b0, 1'b1, 5);
      checkStatus("gaps", 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum: words written, core kept in reset.
      sendFrame(1'b1, 1'b0, -1);
      checkStatus("badChk", 1'b0, 1'b1, 1'b1);
`endif

      // Reset in the middle of a frame.
      pulseStart();
      applyStimulus(8'h02, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      expQ.push_back({BaseAddr, 32'h0000_0013});
      applyStimulus(8'h13, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      Rst_Core   = 1'b1;
      Byte_Valid = 1'b1;
      Byte_Data  = 8'h93;
      wc = writeCount;
      waitCycles(4);
      checkAllZero("midReset");
      checkOutput("midResetWrites", 32'(writeCount), 32'(wc));
      checkOutput("midResetPending", 32'(expQ.size()), 32'd0);
      Rst_Core   = 1'b0;
      Byte_Valid = 1'b0;
      waitCycles(3);
      checkOutput("afterResetWrites", 32'(writeCount), 32'(wc));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
